seq_multiplier_32: RTL and testbench
====================================

SEQ_MULTIPLIER_32 -- requirements
Module: seq_multiplier_32

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  32  operand A; sampled on the accepting edge.
REQ-006 multiplier  input  32  operand B; sampled on the accepting edge.
REQ-007 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; present only when SIGNED_MULT_EN is defined.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid on hi/lo in that cycle.
REQ-010 hi  output  32  upper 32 bits of the last completed product.
REQ-011 lo  output  32  lower 32 bits of the last completed product.

Function
REQ-012 The block SHALL run a shift-add multiply with exactly one 32-bit add per cycle, using the team's 32-bit ripple full-adder with carry-in tied to 0.
REQ-013 States SHALL be IDLE, RUN, FIX (only when SIGNED_MULT_EN is defined) and DONE.
REQ-014 IDLE with start=1 at edge N: latch M=multiplicand, set the 65-bit register P={carry=0, 32'b0, multiplier}, set count=0, go to RUN.
REQ-015 Each RUN edge: if P[0]=1, {c,s}=P[63:32]+M, else {c,s}={0,P[63:32]}; then P={c,s,P[31:1]} and count increments.
REQ-016 After 32 RUN iterations (edge N+32) the state SHALL go to DONE, or to FIX when FIX is compiled in.
REQ-017 DONE: done=1 for exactly one cycle, hi=P[63:32], lo=P[31:0]; the next edge returns to IDLE.
REQ-018 Latency without the macro: done SHALL be high in the cycle after edge N+32. With the macro: in the cycle after edge N+33.
REQ-019 hi/lo SHALL update only on entry to DONE, and SHALL hold their value until the next completion.
REQ-020 start SHALL be ignored in RUN, FIX and DONE; operand changes after the accepting edge SHALL have no effect.
REQ-021 start=1 held continuously SHALL begin a new multiply on each IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
REQ-022 The carry out of bit 31 SHALL be kept in P[64] so that unsigned 0xFFFFFFFF*0xFFFFFFFF does not overflow.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, P=0 and count=0.
REQ-024 Reset during RUN or FIX SHALL abandon the operation with no done pulse; hi/lo SHALL read 0.
REQ-025 Release of reset SHALL take effect at the next rising edge; the first start is accepted in IDLE after that edge.

Configuration
REQ-026 Macro SIGNED_MULT_EN, when defined, SHALL add the is_signed port and the FIX state.
- Accepting edge: operands are converted to magnitudes, and neg = sign(A) XOR sign(B) is latched when is_signed=1.
- FIX always takes one cycle; {hi,lo} is negated (64-bit two's complement) only when neg=1.
REQ-027 Macro SIGNED_MULT_EN, when undefined: no is_signed port, no FIX state, unsigned-only operation, 32-cycle latency.

Verification
REQ-028 Unsigned 3 x 5 -> done after 32 (33 with macro) cycles; hi=0x00000000, lo=0x0000000F; busy high throughout, done high exactly 1 cycle.
REQ-029 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 Macro defined, is_signed=1: 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 start pulsed at cycle 10 of a running 7 x 9 with new operands 2 x 2 -> ignored; result hi=0, lo=0x0000003F; single done pulse.
REQ-032 reset asserted mid-RUN at count=16 -> busy=0, hi=lo=0 immediately; no done pulse; a subsequent 6 x 7 completes with lo=0x0000002A.

Source files
------------

// File: rtl/seq_multiplier_32.sv
// Sequential 32x32 shift-add multiplier: one 32-bit ripple add per cycle, 64-bit product on hi/lo.
// Define SIGNED_MULT_EN to add the is_signed port and a FIX state that applies the product sign.

module ripple_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar g = 0; g < 32; g++) begin : g_fa
        assign sum[g]       = a[g] ^ b[g] ^ w_carry[g];
        assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
    end

    assign cout = w_carry[32];
endmodule

module seq_multiplier_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
`ifdef SIGNED_MULT_EN
    input  logic        is_signed,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);
    // Handshake: start is accepted on a rising edge only while busy=0; operands are
    // captured on that same edge; done pulses for one cycle with hi/lo valid, then busy drops.

`ifdef SIGNED_MULT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_m;
    logic [63:0] r_p;
    logic [5:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_cout;
    logic [63:0] w_p_next;
    logic        w_last;

`ifdef SIGNED_MULT_EN
    logic        r_neg;
    logic        w_neg_a;
    logic        w_neg_b;

    // Work on magnitudes; the sign is reapplied in FIX. 0x80000000 maps to itself, which is the correct magnitude.
    assign w_neg_a = is_signed & multiplicand[31];
    assign w_neg_b = is_signed & multiplier[31];
    assign w_mag_a = w_neg_a ? (32'd0 - multiplicand) : multiplicand;
    assign w_mag_b = w_neg_b ? (32'd0 - multiplier) : multiplier;
`else
    assign w_mag_a = multiplicand;
    assign w_mag_b = multiplier;
`endif

    assign w_addend = r_p[0] ? r_m : 32'd0;

    ripple_adder_32 u_adder (
        .a    (r_p[63:32]),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // The add's carry-out becomes the top product bit after the shift, so all-ones operands cannot overflow.
    assign w_p_next = {w_cout, w_sum, r_p[31:1]};
    assign w_last   = (r_count == 6'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
`ifdef SIGNED_MULT_EN
                    w_state_next = S_FIX;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef SIGNED_MULT_EN
            S_FIX: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m     <= 32'd0;
            r_p     <= 64'd0;
            r_count <= 6'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
`ifdef SIGNED_MULT_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= w_mag_a;
                        r_p     <= {32'd0, w_mag_b};
                        r_count <= 6'd0;
`ifdef SIGNED_MULT_EN
                        r_neg   <= w_neg_a ^ w_neg_b;
`endif
                    end
                end
                S_RUN: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + 6'd1;
`ifndef SIGNED_MULT_EN
                    if (w_last) begin
                        r_hi <= w_p_next[63:32];
                        r_lo <= w_p_next[31:0];
                    end
`endif
                end
`ifdef SIGNED_MULT_EN
                S_FIX: begin
                    {r_hi, r_lo} <= r_neg ? (64'd0 - r_p) : r_p;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_seq_multiplier_32.sv
// Directed bench for seq_multiplier_32; follows SIGNED_MULT_EN to select latency and signed vectors.

module tb_seq_multiplier_32;
`ifdef SIGNED_MULT_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
`ifdef SIGNED_MULT_EN
    logic        is_signed;
`endif
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int          n_cmp;
    int          n_bad;
    logic [63:0] exp_q[$];
    logic [63:0] prev_result;

    seq_multiplier_32 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef SIGNED_MULT_EN
        .is_signed    (is_signed),
`endif
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        multiplicand = a;
        multiplier   = b;
`ifdef SIGNED_MULT_EN
        is_signed    = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    // Called #1 after the accepting edge; waits for done and checks the popped expectation.
    task automatic wait_done(input string tag, input int poke_at);
        int   cyc;
        bit   seen;
        int   bad_busy;
        int   bad_hold;
        logic [63:0] exp_v;
        cyc      = 0;
        seen     = 0;
        bad_busy = (busy !== 1'b1 || done !== 1'b0) ? 1 : 0;
        bad_hold = ({hi, lo} !== prev_result) ? 1 : 0;
        for (int i = 1; i <= LAT + 8; i++) begin
            if (poke_at > 0 && i == poke_at + 1) begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                seen = 1;
                cyc  = i;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if ({hi, lo} !== prev_result) bad_hold++;
            if (poke_at > 0 && i == poke_at) begin
                start = 1'b1;
                set_ops(32'd2, 32'd2, 1'b0);
            end
        end
        check({tag, " busy_during_run"}, 64'(bad_busy), 64'd0);
        check({tag, " hilo_hold"}, 64'(bad_hold), 64'd0);
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        exp_v = exp_q.pop_front();
        if (seen) begin
            check({tag, " latency"}, 64'(cyc), 64'(LAT));
            check({tag, " result"}, {hi, lo}, exp_v);
            check({tag, " busy_in_done"}, 64'(busy), 64'd1);
        end
        prev_result = exp_v;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic [63:0] exp_v, input int poke_at);
        set_ops(a, b, sgn);
        start = 1'b1;
        exp_q.push_back(exp_v);
        tick();
        start = 1'b0;
        set_ops($urandom, $urandom, sgn);
        wait_done(tag, poke_at);
        tick();
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " result_held"}, {hi, lo}, exp_v);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int stray_done;
        n_cmp       = 0;
        n_bad       = 0;
        prev_result = 64'd0;
        reset       = 1'b1;
        start       = 1'b0;
        set_ops(32'd0, 32'd0, 1'b0);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_mult("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
        run_mult("u_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
        run_mult("u_zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 0);
        run_mult("u_by_one", 32'h1234_5678, 32'd1, 1'b0, 64'h0000_0000_1234_5678, 0);
        run_mult("u_2p16sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 0);
        run_mult("u_ones_x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 0);
        run_mult("u_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0);
        run_mult("u_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 0);
        run_mult("start_ignored", 32'd7, 32'd9, 1'b0, 64'h0000_0000_0000_003F, 10);

`ifdef SIGNED_MULT_EN
        run_mult("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        run_mult("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
        run_mult("s_m7xm6", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'h0000_0000_0000_002A, 0);
        run_mult("s_5xm1", 32'd5, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0);
`endif

        // Back-to-back with start held high: second operands are already present during the first run.
        set_ops(32'd3, 32'd5, 1'b0);
        start = 1'b1;
        exp_q.push_back(64'd15);
        exp_q.push_back(64'd24);
        tick();
        set_ops(32'd4, 32'd6, 1'b0);
        wait_done("b2b_first", 0);
        tick();
        check("b2b idle_gap busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        set_ops($urandom, $urandom, 1'b0);
        wait_done("b2b_second", 0);
        tick();
        check("b2b done_one_cycle", 64'(done), 64'd0);
        check("b2b busy_after", 64'(busy), 64'd0);

        // Reset in the middle of a run, with a nonzero previous result on hi/lo.
        run_mult("pre_reset", 32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, 0);
        set_ops(32'd11, 32'd13, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("mid_run state", 64'(dbg_state), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_reset busy", 64'(busy), 64'd0);
        check("mid_reset done", 64'(done), 64'd0);
        check("mid_reset hilo", {hi, lo}, 64'd0);
        check("mid_reset state", 64'(dbg_state), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        prev_result = 64'd0;
        stray_done  = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            tick();
            if (done === 1'b1 || busy !== 1'b0) stray_done++;
        end
        check("after_reset no_done", 64'(stray_done), 64'd0);
        check("after_reset hilo", {hi, lo}, 64'd0);
        run_mult("post_reset6x7", 32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A, 0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
